// File: rtl/marshal_pkg.sv
// Shared types and constants for the serial-to-byte marshalling path.
package marshal_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam logic [BYTE_W-1:0] SYNC_DEFAULT = 8'hA5;

  typedef enum logic [1:0] {
    IDLE,
    HUNT,
    PAYLOAD
  } state_e;

  typedef struct packed {
    logic              sof;
    logic              eof;
    logic [BYTE_W-1:0] data;
  } entry_t;

endpackage

// File: rtl/marshal_frame_ctrl_if.sv
// Byte-stream handshake between the frame controller and its consumer.
interface marshal_frame_ctrl_if;
  import marshal_pkg::*;

  logic [BYTE_W-1:0] byte_out;
  logic              byte_sof;
  logic              byte_eof;
  logic              byte_valid;
  logic              byte_ready;

  modport master (
    output byte_out,
    output byte_sof,
    output byte_eof,
    output byte_valid,
    input  byte_ready
  );

  modport slave (
    input  byte_out,
    input  byte_sof,
    input  byte_eof,
    input  byte_valid,
    output byte_ready
  );

endinterface

// File: rtl/marshal_fifo.sv
// Synchronous first-word-fall-through FIFO of tagged byte entries.
module marshal_fifo
  import marshal_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push,
  input  entry_t din,
  input  logic   pop,
  output entry_t dout,
  output logic   full,
  output logic   empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  entry_t          mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;
  logic            do_push;
  logic            do_pop;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];

  // A pop frees the head slot this edge, so a push into a full FIFO still lands.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/marshal_frame_ctrl.sv
// Sync-hunting frame controller: assembles LSB-first payload bytes into a tagged output FIFO.
module marshal_frame_ctrl
  import marshal_pkg::*;
#(
  parameter int unsigned LEN_W = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned FRM_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  serial_in,
  input  logic                  serial_valid,
  input  logic                  cfg_en,
  input  logic [BYTE_W-1:0]     cfg_sync,
  input  logic [LEN_W-1:0]      cfg_len,
  input  logic                  ovf_clr,
  marshal_frame_ctrl_if.master  bus,
  output logic                  overflow,
  output logic                  in_frame,
  output logic [FRM_W-1:0]      frame_cnt
);

  state_e             state;
  state_e             state_next;
  logic [BYTE_W-1:0]  window;
  logic [3:0]         fill_cnt;
  logic [2:0]         bit_cnt;
  logic [LEN_W-1:0]   byte_cnt;
  logic [LEN_W-1:0]   len_q;
  logic [BYTE_W-1:0]  asm_q;

  logic [BYTE_W-1:0]  win_shift;
  logic [BYTE_W-1:0]  asm_byte;
  logic               hunt_bit;
  logic               pay_bit;
  logic               match;
  logic               byte_done;
  logic               last_byte;
  logic               frame_done;
  logic               push_req;
  entry_t             push_entry;

  entry_t             head;
  logic               fifo_full;
  logic               fifo_empty;
  logic               pop;
  logic               drop;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    win_shift  = {serial_in, window[BYTE_W-1:1]};
    asm_byte   = asm_q;
    asm_byte[bit_cnt] = serial_in;
    hunt_bit   = cfg_en && serial_valid && (state == HUNT);
    pay_bit    = cfg_en && serial_valid && (state == PAYLOAD);
    // The window counts as full once the current bit is the eighth one shifted in.
    match      = hunt_bit && (fill_cnt >= 4'd7) && (win_shift == cfg_sync);
    byte_done  = pay_bit && (bit_cnt == 3'd7);
    last_byte  = (byte_cnt == len_q - 1'b1);
    push_req   = byte_done;
    push_entry.sof  = (byte_cnt == '0);
    push_entry.eof  = last_byte;
    push_entry.data = asm_byte;
    frame_done = (match && (cfg_len == '0)) || (byte_done && last_byte);

    if (!cfg_en) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    state_next = HUNT;
        HUNT:    if (match && (cfg_len != '0)) state_next = PAYLOAD;
        PAYLOAD: if (byte_done && last_byte) state_next = HUNT;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      window    <= '0;
      fill_cnt  <= '0;
      bit_cnt   <= '0;
      byte_cnt  <= '0;
      len_q     <= '0;
      asm_q     <= '0;
      frame_cnt <= '0;
    end else begin
      if (!cfg_en || (state == IDLE)) begin
        fill_cnt <= '0;
        bit_cnt  <= '0;
        byte_cnt <= '0;
      end else if (hunt_bit) begin
        window <= win_shift;
        if (match) begin
          len_q    <= cfg_len;
          bit_cnt  <= '0;
          byte_cnt <= '0;
          if (cfg_len == '0) fill_cnt <= '0;
        end else if (fill_cnt != 4'd8) begin
          fill_cnt <= fill_cnt + 1'b1;
        end
      end else if (pay_bit) begin
        asm_q   <= asm_byte;
        bit_cnt <= bit_cnt + 1'b1;
        if (byte_done) begin
          byte_cnt <= byte_cnt + 1'b1;
          if (last_byte) fill_cnt <= '0;
        end
      end
      if (frame_done) frame_cnt <= frame_cnt + 1'b1;
    end
  end

  assign pop  = !fifo_empty && bus.byte_ready;
  assign drop = push_req && fifo_full && !pop;

  always_ff @(posedge clk) begin
    if (rst)          overflow <= 1'b0;
    else if (drop)    overflow <= 1'b1;
    else if (ovf_clr) overflow <= 1'b0;
  end

  marshal_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_req),
    .din   (push_entry),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign bus.byte_valid = !fifo_empty;
  assign bus.byte_out   = fifo_empty ? '0 : head.data;
  assign bus.byte_sof   = !fifo_empty && head.sof;
  assign bus.byte_eof   = !fifo_empty && head.eof;
  assign in_frame       = (state == PAYLOAD);

endmodule

// File: tb/tb_marshal_frame_ctrl.sv
// Directed scenario bench for marshal_frame_ctrl.
module tb_marshal_frame_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        serial_in = 1'b0;
  logic        serial_valid = 1'b0;
  logic        cfg_en = 1'b0;
  logic [7:0]  cfg_sync = 8'hA5;
  logic [7:0]  cfg_len = 8'd2;
  logic        ovf_clr = 1'b0;
  logic        overflow;
  logic        in_frame;
  logic [15:0] frame_cnt;

  int unsigned total = 0;
  int unsigned bad = 0;

  logic [9:0] got [$];

  marshal_frame_ctrl_if bus ();

  marshal_frame_ctrl #(
    .LEN_W (8),
    .DEPTH (4),
    .FRM_W (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .serial_in    (serial_in),
    .serial_valid (serial_valid),
    .cfg_en       (cfg_en),
    .cfg_sync     (cfg_sync),
    .cfg_len      (cfg_len),
    .ovf_clr      (ovf_clr),
    .bus          (bus),
    .overflow     (overflow),
    .in_frame     (in_frame),
    .frame_cnt    (frame_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.byte_valid && bus.byte_ready)
      got.push_back({bus.byte_sof, bus.byte_eof, bus.byte_out});
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cfg_en = 1'b0;
    idle(2);
    rst = 1'b0;
    cfg_en = 1'b1;
    got.delete();
    @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    serial_in = b;
    serial_valid = 1'b1;
    @(negedge clk);
    serial_valid = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
  endtask

  task automatic test_reset();
    bus.byte_ready = 1'b0;
    rst = 1'b1;
    idle(2);
    total++;
    if ({bus.byte_valid, bus.byte_out, bus.byte_sof, bus.byte_eof, overflow, in_frame, frame_cnt} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: valid=%b out=%h sof=%b eof=%b ovf=%b in_frame=%b frames=%0d, required all 0",
               bus.byte_valid, bus.byte_out, bus.byte_sof, bus.byte_eof, overflow, in_frame, frame_cnt);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    cfg_len = 8'd2;
    bus.byte_ready = 1'b1;
    do_reset();
    send_byte(8'hA5);
    total++;
    if (in_frame !== 1'b1) begin
      bad++; $display("FAIL basic_in_frame_after_sync: got=%b required=1", in_frame);
    end
    send_byte(8'h3C);
    total++;
    if (bus.byte_valid !== 1'b1 || bus.byte_out !== 8'h3C || bus.byte_sof !== 1'b1) begin
      bad++;
      $display("FAIL basic_latency: valid=%b out=%h sof=%b required valid=1 out=3c sof=1",
               bus.byte_valid, bus.byte_out, bus.byte_sof);
    end
    send_byte(8'h81);
    total++;
    if (in_frame !== 1'b0 || frame_cnt !== 16'd1) begin
      bad++; $display("FAIL basic_frame_end: in_frame=%b frames=%0d required 0/1", in_frame, frame_cnt);
    end
    idle(3);
    total++;
    if (got.size() != 2 || got[0] !== {2'b10, 8'h3C} || got[1] !== {2'b01, 8'h81}) begin
      bad++;
      $display("FAIL basic_bytes: n=%0d first=%h second=%h required n=2 first=23c second=181",
               got.size(), (got.size() > 0) ? got[0] : 10'h0, (got.size() > 1) ? got[1] : 10'h0);
    end
  endtask

  task automatic test_hunt();
    cfg_len = 8'd1;
    bus.byte_ready = 1'b1;
    do_reset();
    send_byte(8'h00);
    send_byte(8'h52);
    total++;
    if (in_frame !== 1'b0) begin
      bad++; $display("FAIL hunt_no_false_sync: in_frame=%b required=0", in_frame);
    end
    send_byte(8'hA5);
    send_byte(8'h7E);
    idle(3);
    total++;
    if (got.size() != 1 || got[0] !== {2'b11, 8'h7E} || frame_cnt !== 16'd1) begin
      bad++;
      $display("FAIL hunt_single_byte: n=%0d first=%h frames=%0d required n=1 first=37e frames=1",
               got.size(), (got.size() > 0) ? got[0] : 10'h0, frame_cnt);
    end
  endtask

  task automatic test_overflow();
    logic [7:0] pay [6];
    pay = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    cfg_len = 8'd6;
    bus.byte_ready = 1'b0;
    do_reset();
    send_byte(8'hA5);
    for (int i = 0; i < 6; i++) send_byte(pay[i]);
    total++;
    if (overflow !== 1'b1 || frame_cnt !== 16'd1 || bus.byte_valid !== 1'b1 ||
        bus.byte_out !== 8'h11 || bus.byte_sof !== 1'b1 || got.size() != 0) begin
      bad++;
      $display("FAIL ovf_held: ovf=%b frames=%0d valid=%b out=%h sof=%b n=%0d required 1/1/1/11/1/0",
               overflow, frame_cnt, bus.byte_valid, bus.byte_out, bus.byte_sof, got.size());
    end
    bus.byte_ready = 1'b1;
    idle(6);
    total++;
    if (got.size() != 4 || got[0] !== {2'b10, 8'h11} || got[1] !== {2'b00, 8'h22} ||
        got[2] !== {2'b00, 8'h33} || got[3] !== {2'b00, 8'h44}) begin
      bad++;
      $display("FAIL ovf_drain: n=%0d required 4 bytes 211,022,033,044 in order", got.size());
    end
    total++;
    if (overflow !== 1'b1) begin
      bad++; $display("FAIL ovf_sticky: got=%b required=1", overflow);
    end
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    total++;
    if (overflow !== 1'b0 || bus.byte_valid !== 1'b0) begin
      bad++; $display("FAIL ovf_clear: ovf=%b valid=%b required 0/0", overflow, bus.byte_valid);
    end
  endtask

  task automatic test_gapped();
    logic [7:0] bytes [3];
    bytes = '{8'hA5, 8'h3C, 8'h81};
    cfg_len = 8'd2;
    bus.byte_ready = 1'b1;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 8; i++) begin
        send_bit(bytes[k][i]);
        serial_in = ~bytes[k][i];
        @(negedge clk);
      end
    end
    idle(3);
    total++;
    if (got.size() != 2 || got[0] !== {2'b10, 8'h3C} || got[1] !== {2'b01, 8'h81} || frame_cnt !== 16'd1) begin
      bad++;
      $display("FAIL gapped_bytes: n=%0d first=%h second=%h frames=%0d required 2/23c/181/1",
               got.size(), (got.size() > 0) ? got[0] : 10'h0, (got.size() > 1) ? got[1] : 10'h0, frame_cnt);
    end
  endtask

  task automatic test_en_drop();
    cfg_len = 8'd2;
    bus.byte_ready = 1'b0;
    do_reset();
    send_byte(8'hA5);
    send_byte(8'h3C);
    send_byte(8'h81);
    send_byte(8'hA5);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    cfg_en = 1'b0;
    idle(2);
    total++;
    if (in_frame !== 1'b0 || frame_cnt !== 16'd1) begin
      bad++; $display("FAIL endrop_idle: in_frame=%b frames=%0d required 0/1", in_frame, frame_cnt);
    end
    cfg_en = 1'b1;
    @(negedge clk);
    send_byte(8'hA5);
    send_byte(8'h5A);
    send_byte(8'hC3);
    bus.byte_ready = 1'b1;
    idle(6);
    total++;
    if (got.size() != 4 || got[0] !== {2'b10, 8'h3C} || got[1] !== {2'b01, 8'h81} ||
        got[2] !== {2'b10, 8'h5A} || got[3] !== {2'b01, 8'hC3} || frame_cnt !== 16'd2) begin
      bad++;
      $display("FAIL endrop_bytes: n=%0d frames=%0d required 4 bytes 23c,181,25a,1c3 and frames=2",
               got.size(), frame_cnt);
    end
  endtask

  task automatic test_reset_mid();
    cfg_len = 8'd2;
    bus.byte_ready = 1'b0;
    do_reset();
    send_byte(8'hA5);
    send_byte(8'h3C);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    total++;
    if (in_frame !== 1'b1 || bus.byte_valid !== 1'b1) begin
      bad++; $display("FAIL rstmid_pre: in_frame=%b valid=%b required 1/1", in_frame, bus.byte_valid);
    end
    rst = 1'b1;
    @(negedge clk);
    total++;
    if ({bus.byte_valid, bus.byte_out, bus.byte_sof, bus.byte_eof, overflow, in_frame, frame_cnt} !== '0) begin
      bad++;
      $display("FAIL rstmid_outputs: valid=%b out=%h in_frame=%b frames=%0d required all 0",
               bus.byte_valid, bus.byte_out, in_frame, frame_cnt);
    end
    rst = 1'b0;
    cfg_len = 8'd0;
    bus.byte_ready = 1'b1;
    got.delete();
    @(negedge clk);
    send_byte(8'hA5);
    send_byte(8'hA5);
    idle(3);
    total++;
    if (frame_cnt !== 16'd2 || got.size() != 0 || in_frame !== 1'b0) begin
      bad++;
      $display("FAIL len0_frames: frames=%0d n=%0d in_frame=%b required 2/0/0", frame_cnt, got.size(), in_frame);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_hunt();
    test_overflow();
    test_gapped();
    test_en_drop();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
